// File: rtl/adc_pkg.sv
// Shared types and default timing for the ADC0809 conversion controller.
package adc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_LO,
      WAIT_HI,
      READ,
      DONE
   } adc_state_t;

   localparam int DEF_SAMPLE_PERIOD = 50000;
   localparam int DEF_START_W       = 10;
   localparam int DEF_EOC_TIMEOUT   = 20000;
   localparam int DEF_OE_SETTLE     = 2;
   localparam int ADC_DW            = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser with synchronous active-high reset.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/adc0809_ctrl.sv
// ADC0809 conversion sequencer: periodic launch, EOC handshake with timeout,
// OE-gated read and a one-cycle sample strobe for the display path.
//
// state   | meaning
// IDLE    | waiting for en and the period counter to saturate
// START   | adc_start/adc_ale high for START_W cycles
// WAIT_LO | waiting for synchronised EOC to fall (timeout guarded)
// WAIT_HI | waiting for synchronised EOC to rise (timeout guarded)
// READ    | adc_oe high for OE_SETTLE+1 cycles, bus latched on the last one
// DONE    | sample_valid strobe
module adc0809_ctrl
   import adc_pkg::*;
#(
   parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
   parameter int START_W       = DEF_START_W,
   parameter int EOC_TIMEOUT   = DEF_EOC_TIMEOUT,
   parameter int OE_SETTLE     = DEF_OE_SETTLE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [2:0]        ch_sel,
   input  logic              adc_eoc,
   input  logic [ADC_DW-1:0] adc_d,
   output logic              adc_start,
   output logic              adc_ale,
   output logic [2:0]        adc_addr,
   output logic              adc_oe,
   output logic [ADC_DW-1:0] sample,
   output logic [2:0]        sample_ch,
   output logic              sample_valid,
   output logic              timeout_err,
   output logic              busy
);

   localparam int PER_W = $clog2(SAMPLE_PERIOD);
   localparam int TMR_W = $clog2(max3(START_W, EOC_TIMEOUT, OE_SETTLE + 1) + 1);

   localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
   localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_W - 1);
   localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(EOC_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] OE_LAST    = TMR_W'(OE_SETTLE);

   adc_state_t       state;
   adc_state_t       state_nxt;
   logic [PER_W-1:0] per_cnt;
   logic [TMR_W-1:0] tmr;
   logic             eoc_s;
   logic             launch;
   logic             abort;
   logic             latch;

   sync2 #(.W(1)) u_eoc_sync (
      .clk (clk),
      .rst (rst),
      .d   (adc_eoc),
      .q   (eoc_s)
   );

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      abort     = 1'b0;
      latch     = 1'b0;
      case (state)
         IDLE: begin
            if (en && (per_cnt == PER_LAST)) begin
               state_nxt = START;
               launch    = 1'b1;
            end
         end
         START: begin
            if (tmr == START_LAST) state_nxt = WAIT_LO;
         end
         WAIT_LO: begin
            if (!eoc_s) begin
               state_nxt = WAIT_HI;
            end else if (tmr == TO_LAST) begin
               state_nxt = IDLE;
               abort     = 1'b1;
            end
         end
         WAIT_HI: begin
            if (eoc_s) begin
               state_nxt = READ;
            end else if (tmr == TO_LAST) begin
               state_nxt = IDLE;
               abort     = 1'b1;
            end
         end
         READ: begin
            if (tmr == OE_LAST) begin
               state_nxt = DONE;
               latch     = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The phase timer restarts on every state change and idles at zero in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         per_cnt     <= PER_LAST;
         tmr         <= '0;
         adc_addr    <= '0;
         sample      <= '0;
         sample_ch   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         timeout_err <= abort;
         if (launch) begin
            per_cnt <= '0;
         end else if (per_cnt != PER_LAST) begin
            per_cnt <= per_cnt + 1'b1;
         end
         if (state_nxt != state) begin
            tmr <= '0;
         end else if (state != IDLE) begin
            tmr <= tmr + 1'b1;
         end
         if (launch) adc_addr <= ch_sel;
         if (latch) begin
            sample    <= adc_d;
            sample_ch <= adc_addr;
         end
      end
   end

   assign adc_start    = (state == START);
   assign adc_ale      = (state == START);
   assign adc_oe       = (state == READ);
   assign sample_valid = (state == DONE);
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_adc0809_ctrl.sv
// Directed bench for adc0809_ctrl with a behavioural ADC0809 and a sample scoreboard.
module tb_adc0809_ctrl;

   localparam int P   = 400;
   localparam int SW  = 10;
   localparam int TO  = 120;
   localparam int OES = 2;

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] ch;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] ch_sel = 3'd3;
   logic       adc_eoc = 1'b1;
   logic [7:0] adc_d;
   logic       adc_start, adc_ale, adc_oe, sample_valid, timeout_err, busy;
   logic [2:0] adc_addr, sample_ch;
   logic [7:0] sample;

   logic [7:0] d_val = 8'hA7;
   logic       eoc_stuck = 1'b0;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int rise_cnt = 0, valid_cnt = 0, to_cnt = 0, eoc_fall_cnt = 0;
   int rise_cyc = 0, prev_rise_cyc = 0, fall_cyc = 0, start_w = 0, to_cyc = 0;
   logic [2:0] addr_at_rise = '0;
   logic prev_start = 1'b0, prev_eoc = 1'b1;
   exp_t q[$];

   adc0809_ctrl #(
      .SAMPLE_PERIOD (P),
      .START_W       (SW),
      .EOC_TIMEOUT   (TO),
      .OE_SETTLE     (OES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .ch_sel       (ch_sel),
      .adc_eoc      (adc_eoc),
      .adc_d        (adc_d),
      .adc_start    (adc_start),
      .adc_ale      (adc_ale),
      .adc_addr     (adc_addr),
      .adc_oe       (adc_oe),
      .sample       (sample),
      .sample_ch    (sample_ch),
      .sample_valid (sample_valid),
      .timeout_err  (timeout_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Tri-state bus: only meaningful while the controller drives OE.
   assign adc_d = adc_oe ? d_val : 8'hzz;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // EOC drops 5 cycles after START ends and returns 40 cycles later.
   initial forever begin
      @(negedge adc_start);
      if (!eoc_stuck && !rst) begin
         repeat (5) @(negedge clk);
         adc_eoc = 1'b0;
         repeat (40) @(negedge clk);
         adc_eoc = 1'b1;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      check("oe_start_excl", {31'd0, adc_oe & adc_start}, 0);
      check("valid_err_excl", {31'd0, sample_valid & timeout_err}, 0);
      check("ale_eq_start", {31'd0, adc_ale}, {31'd0, adc_start});
      if (adc_start && !prev_start) begin
         prev_rise_cyc = rise_cyc;
         rise_cyc      = cyc;
         rise_cnt++;
         addr_at_rise  = adc_addr;
      end
      if (!adc_start && prev_start) begin
         fall_cyc = cyc;
         start_w  = cyc - rise_cyc;
      end
      if (timeout_err) begin
         to_cnt++;
         to_cyc = cyc;
      end
      if (!adc_eoc && prev_eoc) eoc_fall_cnt++;
      if (sample_valid) begin
         valid_cnt++;
         check("sb_nonempty", {31'd0, q.size() > 0}, 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("sample", {24'd0, sample}, {24'd0, e.d});
            check("sample_ch", {29'd0, sample_ch}, {29'd0, e.ch});
         end
      end
      prev_start = adc_start;
      prev_eoc   = adc_eoc;
   end

   function automatic int cnt_of(input int which);
      case (which)
         0:       return valid_cnt;
         1:       return rise_cnt;
         2:       return to_cnt;
         default: return eoc_fall_cnt;
      endcase
   endfunction

   task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
      int i = 0;
      while (cnt_of(which) < target && i < budget) begin
         @(negedge clk); #1;
         i++;
      end
      check(tag, {31'd0, cnt_of(which) >= target}, 1);
   endtask

   initial begin
      int i;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_sample", {24'd0, sample}, 0);
      check("rst_sample_ch", {29'd0, sample_ch}, 0);
      check("rst_addr", {29'd0, adc_addr}, 0);
      check("rst_start", {31'd0, adc_start}, 0);
      check("rst_oe", {31'd0, adc_oe}, 0);
      check("rst_valid", {31'd0, sample_valid}, 0);
      check("rst_timeout", {31'd0, timeout_err}, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("no_launch_en0", rise_cnt, 0);

      // Nominal conversion, immediate first launch
      q.push_back('{d: 8'hA7, ch: 3'd3});
      en = 1'b1;
      wait_cnt("launch1", 1, 1, 5);
      check("addr1", {29'd0, addr_at_rise}, 3);
      wait_cnt("valid1", 0, 1, 200);
      check("start_w1", start_w, SW);
      @(negedge clk); #1;
      check("busy_after1", {31'd0, busy}, 0);

      // Period and bus boundaries
      d_val = 8'h00;
      q.push_back('{d: 8'h00, ch: 3'd3});
      wait_cnt("launch2", 1, 2, P + 10);
      check("period12", rise_cyc - prev_rise_cyc, P);
      wait_cnt("valid2", 0, 2, 200);
      d_val = 8'hFF;
      q.push_back('{d: 8'hFF, ch: 3'd3});
      wait_cnt("launch3", 1, 3, P + 10);
      check("period23", rise_cyc - prev_rise_cyc, P);
      wait_cnt("valid3", 0, 3, 200);

      // Stuck EOC
      eoc_stuck = 1'b1;
      wait_cnt("launch4", 1, 4, P + 10);
      check("period34", rise_cyc - prev_rise_cyc, P);
      wait_cnt("timeout", 2, 1, SW + TO + 20);
      check("to_delay", to_cyc - fall_cyc, TO);
      eoc_stuck = 1'b0;
      d_val = 8'h3C;
      q.push_back('{d: 8'h3C, ch: 3'd3});
      repeat (2) @(negedge clk);
      #1;
      check("to_once", to_cnt, 1);
      check("no_valid_on_to", valid_cnt, 3);
      check("sample_kept", {24'd0, sample}, 32'hFF);
      wait_cnt("launch5", 1, 5, P + 10);
      check("period_after_to", rise_cyc - prev_rise_cyc, P);
      wait_cnt("valid4", 0, 4, 200);

      // Enable and channel gating during WAIT_HI
      d_val = 8'h5A;
      q.push_back('{d: 8'h5A, ch: 3'd3});
      wait_cnt("launch6", 1, 6, P + 10);
      wait_cnt("eoc_fall6", 3, 5, 50);
      repeat (10) @(negedge clk);
      #1;
      en = 1'b0;
      ch_sel = 3'd5;
      wait_cnt("valid5", 0, 5, 200);
      repeat (P + 50) @(negedge clk);
      #1;
      check("no_launch_en0b", rise_cnt, 6);
      d_val = 8'hC3;
      q.push_back('{d: 8'hC3, ch: 3'd5});
      en = 1'b1;
      wait_cnt("launch7", 1, 7, 3);
      check("addr7", {29'd0, addr_at_rise}, 5);
      wait_cnt("valid6", 0, 6, 200);

      // Reset during READ
      wait_cnt("launch8", 1, 8, P + 10);
      i = 0;
      while (!adc_oe && i < 200) begin
         @(negedge clk); #1;
         i++;
      end
      check("oe_seen", {31'd0, adc_oe}, 1);
      rst = 1'b1;
      en = 1'b0;
      @(negedge clk); #1;
      check("rr_oe", {31'd0, adc_oe}, 0);
      check("rr_busy", {31'd0, busy}, 0);
      check("rr_sample", {24'd0, sample}, 0);
      check("rr_sample_ch", {29'd0, sample_ch}, 0);
      check("rr_start", {31'd0, adc_start}, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("rr_no_valid", valid_cnt, 6);
      check("sb_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
